// File: rtl/fetch_branch_unit_pkg.sv
// Shared definitions for the fetch/branch unit: condition codes, flag bit positions,
// opcode fields and the fetch FSM state type.
package fetch_branch_unit_pkg;

   localparam logic [3:0] EQ = 4'h0;
   localparam logic [3:0] NE = 4'h1;
   localparam logic [3:0] CS = 4'h2;
   localparam logic [3:0] CC = 4'h3;
   localparam logic [3:0] HI = 4'h4;
   localparam logic [3:0] LS = 4'h5;
   localparam logic [3:0] GT = 4'h6;
   localparam logic [3:0] LE = 4'h7;
   localparam logic [3:0] FS = 4'h8;
   localparam logic [3:0] FC = 4'h9;
   localparam logic [3:0] LO = 4'hA;
   localparam logic [3:0] HS = 4'hB;
   localparam logic [3:0] LT = 4'hC;
   localparam logic [3:0] GE = 4'hD;
   localparam logic [3:0] UC = 4'hE;
   localparam logic [3:0] NV = 4'hF;

   localparam int unsigned FLG_C = 0;
   localparam int unsigned FLG_L = 1;
   localparam int unsigned FLG_F = 2;
   localparam int unsigned FLG_Z = 3;
   localparam int unsigned FLG_N = 4;

   localparam logic [3:0]  OP_BCOND   = 4'hC;
   localparam logic [3:0]  OP_EXT     = 4'h4;
   localparam logic [3:0]  EXT_JCOND  = 4'hC;
   localparam logic [3:0]  EXT_JAL    = 4'h8;
   localparam logic [15:0] INSTR_WAIT = 16'h0000;

   typedef enum logic [1:0] {
      ST_FETCH   = 2'd0,
      ST_WAITMEM = 2'd1,
      ST_ISSUE   = 2'd2,
      ST_HALT    = 2'd3
   } fbu_state_t;

endpackage

// File: rtl/fetch_branch_unit_branch_cond_eval.sv
// Combinational condition-code evaluator over the {N,Z,F,L,C} processor flags.
module branch_cond_eval
   import fetch_branch_unit_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [4:0] flags,
   output logic       take
);

   logic n, z, f, l, c;

   assign n = flags[FLG_N];
   assign z = flags[FLG_Z];
   assign f = flags[FLG_F];
   assign l = flags[FLG_L];
   assign c = flags[FLG_C];

   always_comb begin
      take = 1'b0;
      case (cond)
         EQ: take = z;
         NE: take = ~z;
         CS: take = c;
         CC: take = ~c;
         HI: take = l;
         LS: take = ~l;
         GT: take = n;
         LE: take = ~n;
         FS: take = f;
         FC: take = ~f;
         LO: take = ~l & ~z;
         HS: take = l | z;
         LT: take = ~n & ~z;
         GE: take = n | z;
         UC: take = 1'b1;
         NV: take = 1'b0;
      endcase
   end

endmodule

// File: rtl/fetch_branch_unit.sv
// Instruction-fetch stage: owns the PC, fetches into the instruction register and
// selects the next PC (sequential, Bcond, Jcond, JAL) when the control FSM retires.
module fetch_branch_unit
   import fetch_branch_unit_pkg::*;
#(
   parameter int unsigned    AW       = 10,
   parameter logic [AW-1:0]  RESET_PC = '0
) (
   input  logic          clk,
   input  logic          reset,
   output logic [AW-1:0] imem_addr,
   output logic          imem_req,
   input  logic [15:0]   imem_data,
   input  logic          imem_valid,
   output logic [15:0]   instr,
   output logic          instr_valid,
   input  logic          instr_ready,
   input  logic [4:0]    flags_in,
   input  logic [15:0]   jtarget,
   output logic [AW-1:0] pc,
   output logic          link_we,
   output logic [15:0]   link_addr,
   output logic          branch_taken,
   output logic          halted
);

   fbu_state_t state;

   logic          is_bcond, is_jcond, is_jal;
   logic          cond_take, taken;
   logic [AW-1:0] pc_seq, pc_rel, pc_reg, next_pc;
   logic          unused_jtarget;

   assign unused_jtarget = &{1'b0, jtarget[15:AW]};

   branch_cond_eval u_cond (
      .cond  (instr[11:8]),
      .flags (flags_in),
      .take  (cond_take)
   );

   assign is_bcond = (instr[15:12] == OP_BCOND);
   assign is_jcond = (instr[15:12] == OP_EXT) && (instr[7:4] == EXT_JCOND);
   assign is_jal   = (instr[15:12] == OP_EXT) && (instr[7:4] == EXT_JAL);

   // Displacement is sign-extended to AW bits and added to the branch's own address.
   assign pc_seq = pc + 1'b1;
   assign pc_rel = pc + AW'($signed(instr[7:0]));
   assign pc_reg = jtarget[AW-1:0];

   always_comb begin
      taken   = 1'b0;
      next_pc = pc_seq;
      if (is_bcond && cond_take) begin
         taken   = 1'b1;
         next_pc = pc_rel;
      end else if ((is_jcond && cond_take) || is_jal) begin
         taken   = 1'b1;
         next_pc = pc_reg;
      end
   end

   assign imem_addr = pc;

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_FETCH;
         pc           <= RESET_PC;
         imem_req     <= 1'b0;
         instr        <= '0;
         instr_valid  <= 1'b0;
         link_we      <= 1'b0;
         link_addr    <= '0;
         branch_taken <= 1'b0;
         halted       <= 1'b0;
      end else begin
         link_we      <= 1'b0;
         branch_taken <= 1'b0;
         case (state)
            // imem_req is registered: a retire raises it on entry, the post-reset
            // FETCH raises it one cycle late; either way FETCH leaves once it is seen high.
            ST_FETCH: begin
               if (imem_req) begin
                  imem_req <= 1'b0;
                  state    <= ST_WAITMEM;
               end else begin
                  imem_req <= 1'b1;
               end
            end
            ST_WAITMEM: begin
               if (imem_valid) begin
                  instr       <= imem_data;
                  instr_valid <= 1'b1;
                  state       <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (instr_ready) begin
                  instr_valid  <= 1'b0;
                  pc           <= next_pc;
                  branch_taken <= taken;
                  link_we      <= is_jal;
                  if (is_jal) begin
                     link_addr <= 16'(pc_seq);
                  end
                  if (instr == INSTR_WAIT) begin
                     halted <= 1'b1;
                     state  <= ST_HALT;
                  end else begin
                     imem_req <= 1'b1;
                     state    <= ST_FETCH;
                  end
               end
            end
            ST_HALT: begin
               halted <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_branch_unit.sv
// Randomized and directed bench for fetch_branch_unit against a transaction-level model.
module tb_fetch_branch_unit;

   localparam int AW     = 10;
   localparam int RST_PC = 0;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] imem_addr;
   logic          imem_req;
   logic [15:0]   imem_data;
   logic          imem_valid;
   logic [15:0]   instr;
   logic          instr_valid;
   logic          instr_ready;
   logic [4:0]    flags_in;
   logic [15:0]   jtarget;
   logic [AW-1:0] pc;
   logic          link_we;
   logic [15:0]   link_addr;
   logic          branch_taken;
   logic          halted;

   fetch_branch_unit #(.AW(AW), .RESET_PC(10'(RST_PC))) dut (
      .clk          (clk),
      .reset        (reset),
      .imem_addr    (imem_addr),
      .imem_req     (imem_req),
      .imem_data    (imem_data),
      .imem_valid   (imem_valid),
      .instr        (instr),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready),
      .flags_in     (flags_in),
      .jtarget      (jtarget),
      .pc           (pc),
      .link_we      (link_we),
      .link_addr    (link_addr),
      .branch_taken (branch_taken),
      .halted       (halted)
   );

   always #5 clk = ~clk;

   logic [15:0] mem [1024];

   int checks = 0, failures = 0, cyc = 0;
   // stimulus configuration
   int lat_min = 1, lat_max = 1, ready_mode = 0, hold = 0;
   bit rand_flags = 0, jt_from_tab = 1;
   logic [4:0]  flags_cfg = '0;
   logic [15:0] jt_tab [8];
   // memory responder
   bit pend = 0; int pcnt = 0; logic [15:0] pdata = '0;
   // reference model
   int m_pc = RST_PC; bit m_halted = 0, m_fetch_pend = 0;
   bit e_taken = 0, e_link = 0; int e_laddr = 0;
   bit post_reset = 0, req_reset = 0;
   int idle = 0, retire_cnt = 0, taken_cnt = 0, link_cnt = 0, last_laddr = 0;
   int iv_cycles = 0, first_iv_cyc = -1;
   int req_addr_q[$], req_cyc_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit cond_true(input int c, input logic [4:0] f);
      bit n, z, fl, l, cy;
      n = f[4]; z = f[3]; fl = f[2]; l = f[1]; cy = f[0];
      case (c)
         0: return z;          1: return !z;
         2: return cy;         3: return !cy;
         4: return l;          5: return !l;
         6: return n;          7: return !n;
         8: return fl;         9: return !fl;
         10: return !l && !z;  11: return l || z;
         12: return !n && !z;  13: return n || z;
         14: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // One clock: check outputs mid-cycle, drive memory/ready/flags, advance the model.
   task automatic cycle();
      logic [15:0] w;
      int nxt;
      @(negedge clk);
      cyc++;
      idle++;
      if (post_reset) begin
         chk("rst_imem_req", imem_req, 0);
         chk("rst_instr_valid", instr_valid, 0);
         chk("rst_instr", instr, 0);
         chk("rst_pc", pc, RST_PC);
         chk("rst_link_we", link_we, 0);
         chk("rst_link_addr", link_addr, 0);
         chk("rst_branch_taken", branch_taken, 0);
         chk("rst_halted", halted, 0);
         post_reset = 0;
         idle = 0;
      end else begin
         if (imem_req) begin
            chk("req_addr", imem_addr, m_pc);
            chk("req_allowed", !m_halted && !m_fetch_pend, 1);
            m_fetch_pend = 1;
            req_addr_q.push_back(int'(imem_addr));
            req_cyc_q.push_back(cyc);
            idle = 0;
         end
         if (instr_valid) begin
            chk("iv_allowed", m_fetch_pend, 1);
            chk("issue_pc", pc, m_pc);
            chk("issue_instr", instr, mem[m_pc]);
            if (first_iv_cyc < 0) first_iv_cyc = cyc;
            iv_cycles++;
            idle = 0;
         end
         chk("branch_taken", branch_taken, e_taken);
         chk("link_we", link_we, e_link);
         if (e_link) chk("link_addr", link_addr, e_laddr);
         chk("halted", halted, m_halted);
         if (branch_taken) taken_cnt++;
         if (link_we) begin
            link_cnt++;
            last_laddr = int'(link_addr);
         end
         if (!m_halted && idle > 40) begin
            checks++;
            failures++;
            $display("FAIL progress: no request or issue for %0d cycles, limit 40", idle);
            idle = 0;
         end
      end

      imem_valid = 1'b0;
      imem_data  = 16'($urandom);
      if (pend) begin
         if (pcnt == 0) begin
            imem_valid = 1'b1;
            imem_data  = pdata;
            pend       = 0;
         end else begin
            pcnt--;
         end
      end
      if (imem_req) begin
         pend  = 1;
         pcnt  = $urandom_range(lat_max, lat_min) - 1;
         pdata = mem[imem_addr];
      end

      flags_in = rand_flags ? 5'($urandom) : flags_cfg;
      jtarget  = jt_from_tab ? jt_tab[retire_cnt % 8] : 16'($urandom);
      hold     = instr_valid ? hold + 1 : 0;
      case (ready_mode)
         0: instr_ready = 1'b1;
         1: instr_ready = 1'($urandom_range(1, 0));
         default: instr_ready = (hold == 6);
      endcase

      e_taken = 0;
      e_link  = 0;
      if (req_reset) begin
         reset        = 1'b1;
         instr_ready  = 1'b0;
         req_reset    = 0;
         post_reset   = 1;
         m_pc         = RST_PC;
         m_halted     = 0;
         m_fetch_pend = 0;
      end else begin
         reset = 1'b0;
         if (instr_valid && instr_ready) begin
            w   = mem[m_pc];
            nxt = (m_pc + 1) % 1024;
            if (w[15:12] == 4'hC) begin
               if (cond_true(int'(w[11:8]), flags_in)) begin
                  nxt     = (m_pc + int'($signed(w[7:0]))) & 1023;
                  e_taken = 1;
               end
            end else if (w[15:12] == 4'h4 && w[7:4] == 4'hC) begin
               if (cond_true(int'(w[11:8]), flags_in)) begin
                  nxt     = int'(jtarget) & 1023;
                  e_taken = 1;
               end
            end else if (w[15:12] == 4'h4 && w[7:4] == 4'h8) begin
               nxt     = int'(jtarget) & 1023;
               e_taken = 1;
               e_link  = 1;
               e_laddr = (m_pc + 1) % 1024;
            end
            if (w == 16'h0000) m_halted = 1;
            m_fetch_pend = 0;
            m_pc         = nxt;
            retire_cnt++;
         end
      end
   endtask

   task automatic clear_logs();
      req_addr_q.delete();
      req_cyc_q.delete();
      first_iv_cyc = -1;
      retire_cnt = 0; taken_cnt = 0; link_cnt = 0; last_laddr = 0; iv_cycles = 0;
   endtask

   task automatic do_reset();
      req_reset = 1;
      cycle();
      cycle();
      clear_logs();
   endtask

   task automatic run_until_halt(input int budget, input int drain);
      int n = 0;
      while (!m_halted && n < budget) begin
         cycle();
         n++;
      end
      if (!m_halted) begin
         checks++;
         failures++;
         $display("FAIL halt_timeout: not halted after %0d cycles", budget);
      end
      repeat (drain) cycle();
   endtask

   task automatic chk_reqs(input string name, input int exp[$]);
      chk({name, "_count"}, req_addr_q.size(), exp.size());
      foreach (exp[i]) begin
         if (i < req_addr_q.size()) chk(name, req_addr_q[i], exp[i]);
      end
   endtask

   task automatic directed_setup(input logic [4:0] fl, input logic [15:0] jt);
      foreach (mem[i]) mem[i] = 16'h5101;
      foreach (jt_tab[i]) jt_tab[i] = jt;
      flags_cfg = fl; rand_flags = 0; jt_from_tab = 1;
      lat_min = 1; lat_max = 1; ready_mode = 0;
   endtask

   task automatic randomize_mem();
      int r;
      logic [15:0] w;
      foreach (mem[i]) begin
         r = $urandom_range(9, 0);
         w = 16'($urandom);
         if (r <= 2)      w[15:12] = 4'hC;
         else if (r == 3) begin w[15:12] = 4'h4; w[7:4] = 4'hC; end
         else if (r == 4) begin w[15:12] = 4'h4; w[7:4] = 4'h8; end
         else if (r == 5) begin w[15:12] = 4'h4; w[7:4] = 4'h1; end
         else             w[15:12] = 4'h5;
         mem[i] = w;
      end
      mem[$urandom_range(1023, 0)] = 16'h0000;
      mem[$urandom_range(1023, 0)] = 16'h0000;
   endtask

   initial begin
      int e[$];
      reset = 1'b1; instr_ready = 1'b0; imem_valid = 1'b0; imem_data = '0;
      flags_in = '0; jtarget = '0;
      directed_setup(5'b00000, 16'h0000);
      post_reset = 1;
      cycle();
      clear_logs();

      // 1: sequential fetch timing with 1-cycle memory
      directed_setup(5'b00000, 16'h0000);
      mem[0] = 16'h5101; mem[1] = 16'h0000;
      do_reset();
      run_until_halt(200, 3);
      e = '{0, 1};
      chk_reqs("t1_req", e);
      chk("t1_iv_latency", first_iv_cyc - req_cyc_q[0], 2);
      chk("t1_req_spacing", req_cyc_q[1] - req_cyc_q[0], 3);

      // 2: Bcond EQ taken (Z=1) then not taken (Z=0)
      directed_setup(5'b01000, 16'h0000);
      mem[0] = 16'hCE05; mem[5] = 16'hC0FE; mem[3] = 16'h0000;
      do_reset();
      run_until_halt(200, 3);
      e = '{0, 5, 3};
      chk_reqs("t2a_req", e);
      chk("t2a_taken_cnt", taken_cnt, 2);
      directed_setup(5'b00000, 16'h0000);
      mem[0] = 16'hCE05; mem[5] = 16'hC0FE; mem[6] = 16'h0000;
      do_reset();
      run_until_halt(200, 3);
      e = '{0, 5, 6};
      chk_reqs("t2b_req", e);
      chk("t2b_taken_cnt", taken_cnt, 1);

      // 3: JAL with link write
      directed_setup(5'b00000, 16'h0020);
      mem[0] = 16'hCE08; mem[8] = 16'h4583; mem[10'h020] = 16'h0000;
      do_reset();
      run_until_halt(200, 3);
      e = '{0, 8, 32};
      chk_reqs("t3_req", e);
      chk("t3_link_cnt", link_cnt, 1);
      chk("t3_link_addr", last_laddr, 16'h0009);

      // 4: PC wrap and maximum negative displacement
      directed_setup(5'b00000, 16'h0000);
      jt_tab[0] = 16'h03FF; jt_tab[2] = 16'h0001;
      mem[0] = 16'h4EC0; mem[10'h3FF] = 16'h5101; mem[1] = 16'hCE80; mem[10'h381] = 16'h0000;
      do_reset();
      run_until_halt(300, 3);
      e = '{0, 1023, 0, 1, 897};
      chk_reqs("t4_req", e);

      // 5: ready withheld for 5 cycles per instruction
      directed_setup(5'b00000, 16'h0000);
      ready_mode = 2;
      mem[0] = 16'h5101; mem[1] = 16'h5101; mem[2] = 16'h0000;
      do_reset();
      run_until_halt(300, 3);
      e = '{0, 1, 2};
      chk_reqs("t5_req", e);
      chk("t5_retires", retire_cnt, 3);
      chk("t5_iv_cycles", iv_cycles, 18);

      // 6: reset during WAITMEM, stale data must be dropped; WAIT halts
      directed_setup(5'b00000, 16'h0000);
      lat_min = 3; lat_max = 3;
      mem[0] = 16'h5101;
      do_reset();
      for (int i = 0; i < 20 && req_addr_q.size() == 0; i++) cycle();
      mem[0] = 16'h0000;
      do_reset();
      run_until_halt(200, 20);
      e = '{0};
      chk_reqs("t6_req", e);
      chk("t6_halted", halted, 1);

      // randomized run with random latency, ready, flags, targets and resets
      rand_flags = 1; jt_from_tab = 0; ready_mode = 1; lat_min = 1; lat_max = 3;
      randomize_mem();
      do_reset();
      for (int i = 0; i < 6000; i++) begin
         if (m_halted) begin
            randomize_mem();
            req_reset = 1;
         end else if ($urandom_range(299, 0) == 0) begin
            req_reset = 1;
         end
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
